// File: rtl/regslv_reg_block_1.sv
// Register slave: REG1 (64-bit, hw-updatable) and ext_mem_1 (2 x 128-bit),
// both reached through 32-bit bus words with snapshot buffers for atomicity.
module regslv_reg_block_1 #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int EXT_ADDR_WIDTH = 1,
   parameter int EXT_DATA_WIDTH = 128
) (
   input  logic                      fsm_clk,
   input  logic                      fsm_rst,
   input  logic                      req_vld,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      ack_vld,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      ext_mem_1_req_vld,
   output logic                      ext_mem_1_wr_en,
   output logic                      ext_mem_1_rd_en,
   output logic [EXT_ADDR_WIDTH-1:0] ext_mem_1_addr,
   output logic [EXT_DATA_WIDTH-1:0] ext_mem_1_wr_data,
   input  logic                      ext_mem_1_ack_vld,
   input  logic [EXT_DATA_WIDTH-1:0] ext_mem_1_rd_data,
   input  logic [63:0]               REG1__FIELD_0__next_value,
   input  logic                      REG1__FIELD_0__pulse,
   output logic [63:0]               REG1__FIELD_0__curr_value,
   input  logic                      global_sync_reset_in,
   output logic                      global_sync_reset_out
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INT      = 3'd1;
   localparam logic [2:0] S_EXT_REQ  = 3'd2;
   localparam logic [2:0] S_EXT_WAIT = 3'd3;
   localparam logic [2:0] S_ACK      = 3'd4;

   logic [2:0]                state_q, state_d;
   logic                      ack_q, ack_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [63:0]               reg1_q, reg1_d;
   logic [63:0]               snap1_q, snap1_d;
   logic [EXT_DATA_WIDTH-1:0] snapx_q, snapx_d;
   logic                      xreq_q, xreq_d;
   logic                      xwr_q, xwr_d;
   logic                      xrd_q, xrd_d;
   logic [EXT_ADDR_WIDTH-1:0] xaddr_q, xaddr_d;
   logic [EXT_DATA_WIDTH-1:0] xwdata_q, xwdata_d;
   logic                      xpend_rd_q, xpend_rd_d;
   logic                      gsr_q;

   logic       soft_rst;
   logic       upper_zero;
   logic       hit_reg;
   logic       hit_ext;
   logic [1:0] wsel;
   logic       ent;
   logic       is_wr;
   logic       is_rd;
   int         wofs;

   assign soft_rst   = fsm_rst | global_sync_reset_in;
   assign upper_zero = (addr[ADDR_WIDTH-1:6] == '0) && (addr[1:0] == 2'b00);
   assign hit_reg    = upper_zero && (addr[5:3] == 3'b000);
   assign hit_ext    = upper_zero && addr[5];
   assign wsel       = addr[3:2];
   assign ent        = addr[4];
   assign wofs       = int'(wsel) * DATA_WIDTH;
   // Both enables set counts as a write
   assign is_wr      = wr_en;
   assign is_rd      = rd_en & ~wr_en;

   always_comb begin
      state_d    = state_q;
      ack_d      = 1'b0;
      rdata_d    = '0;
      reg1_d     = reg1_q;
      snap1_d    = snap1_q;
      snapx_d    = snapx_q;
      xreq_d     = 1'b0;
      xwr_d      = 1'b0;
      xrd_d      = 1'b0;
      xaddr_d    = '0;
      xwdata_d   = '0;
      xpend_rd_d = xpend_rd_q;

      // Hardware load first so a same-cycle software commit overrides it
      if (REG1__FIELD_0__pulse) begin
         reg1_d = REG1__FIELD_0__next_value;
      end

      unique case (state_q)
         S_IDLE: begin
            if (req_vld && (wr_en || rd_en)) begin
               if (hit_ext && (wsel == 2'd0)) begin
                  xreq_d     = 1'b1;
                  xwr_d      = is_wr;
                  xrd_d      = is_rd;
                  xaddr_d    = EXT_ADDR_WIDTH'(ent);
                  xwdata_d   = {snapx_q[EXT_DATA_WIDTH-1:DATA_WIDTH], wr_data};
                  xpend_rd_d = is_rd;
                  state_d    = S_EXT_REQ;
               end else begin
                  ack_d   = 1'b1;
                  state_d = S_INT;
                  if (hit_reg) begin
                     if (is_wr) begin
                        if (wsel != 2'd0) begin
                           snap1_d[63:32] = wr_data;
                        end else begin
                           reg1_d = {snap1_q[63:32], wr_data};
                        end
                     end else if (wsel != 2'd0) begin
                        rdata_d = snap1_q[63:32];
                     end else begin
                        snap1_d = reg1_q;
                        rdata_d = reg1_q[31:0];
                     end
                  end else if (hit_ext) begin
                     if (is_wr) begin
                        snapx_d[wofs +: DATA_WIDTH] = wr_data;
                     end else begin
                        rdata_d = snapx_q[wofs +: DATA_WIDTH];
                     end
                  end
               end
            end
         end
         S_INT: begin
            state_d = S_IDLE;
         end
         S_EXT_REQ, S_EXT_WAIT: begin
            state_d = S_EXT_WAIT;
            if (ext_mem_1_ack_vld) begin
               ack_d   = 1'b1;
               state_d = S_ACK;
               if (xpend_rd_q) begin
                  snapx_d = ext_mem_1_rd_data;
                  rdata_d = ext_mem_1_rd_data[DATA_WIDTH-1:0];
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge fsm_clk) begin
      if (soft_rst) begin
         state_q    <= S_IDLE;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         reg1_q     <= '0;
         snap1_q    <= '0;
         snapx_q    <= '0;
         xreq_q     <= 1'b0;
         xwr_q      <= 1'b0;
         xrd_q      <= 1'b0;
         xaddr_q    <= '0;
         xwdata_q   <= '0;
         xpend_rd_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         reg1_q     <= reg1_d;
         snap1_q    <= snap1_d;
         snapx_q    <= snapx_d;
         xreq_q     <= xreq_d;
         xwr_q      <= xwr_d;
         xrd_q      <= xrd_d;
         xaddr_q    <= xaddr_d;
         xwdata_q   <= xwdata_d;
         xpend_rd_q <= xpend_rd_d;
      end
      gsr_q <= fsm_rst ? 1'b0 : global_sync_reset_in;
   end

   assign ack_vld                   = ack_q;
   assign rd_data                   = rdata_q;
   assign ext_mem_1_req_vld         = xreq_q;
   assign ext_mem_1_wr_en           = xwr_q;
   assign ext_mem_1_rd_en           = xrd_q;
   assign ext_mem_1_addr            = xaddr_q;
   assign ext_mem_1_wr_data         = xwdata_q;
   assign REG1__FIELD_0__curr_value = reg1_q;
   assign global_sync_reset_out     = gsr_q & ~fsm_rst;

endmodule

// File: tb/tb_regslv_reg_block_1.sv
// Scoreboard bench for regslv_reg_block_1 with a behavioural ext_mem_1.
// Expected acks are queued at issue time and popped by a separate monitor.
module tb_regslv_reg_block_1;

   logic         clk = 1'b0;
   logic         fsm_rst;
   logic         req_vld;
   logic         wr_en;
   logic         rd_en;
   logic [63:0]  addr;
   logic [31:0]  wr_data;
   logic         ack_vld;
   logic [31:0]  rd_data;
   logic         x_req;
   logic         x_wr;
   logic         x_rd;
   logic [0:0]   x_addr;
   logic [127:0] x_wdata;
   logic         x_ack;
   logic [127:0] x_rdata;
   logic [63:0]  hw_nv;
   logic         hw_pulse;
   logic [63:0]  curr;
   logic         gsr_in;
   logic         gsr_out;

   typedef struct {
      logic [31:0] rd;
      int          cyc;
      string       nm;
   } exp_t;

   exp_t         q[$];
   int           cyc = 0;
   int           nvec = 0;
   int           nfail = 0;
   int           nack = 0;
   logic [127:0] mem [2];
   int           ext_dly = 2;
   int           ext_wr_cnt = 0;
   int           ext_rd_cnt = 0;
   logic [127:0] last_wdata = '0;
   logic [0:0]   last_waddr = '0;

   localparam logic [127:0] ALL_A = {32{4'hA}};
   localparam logic [127:0] ALL_F = {128{1'b1}};

   regslv_reg_block_1 dut (
      .fsm_clk                   (clk),
      .fsm_rst                   (fsm_rst),
      .req_vld                   (req_vld),
      .wr_en                     (wr_en),
      .rd_en                     (rd_en),
      .addr                      (addr),
      .wr_data                   (wr_data),
      .ack_vld                   (ack_vld),
      .rd_data                   (rd_data),
      .ext_mem_1_req_vld         (x_req),
      .ext_mem_1_wr_en           (x_wr),
      .ext_mem_1_rd_en           (x_rd),
      .ext_mem_1_addr            (x_addr),
      .ext_mem_1_wr_data         (x_wdata),
      .ext_mem_1_ack_vld         (x_ack),
      .ext_mem_1_rd_data         (x_rdata),
      .REG1__FIELD_0__next_value (hw_nv),
      .REG1__FIELD_0__pulse      (hw_pulse),
      .REG1__FIELD_0__curr_value (curr),
      .global_sync_reset_in      (gsr_in),
      .global_sync_reset_out     (gsr_out)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [127:0] act,
                               logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endfunction

   // Monitor: every ack pops one expectation; rd_data must idle at 0
   initial forever begin
      @(posedge clk);
      #1;
      if (ack_vld === 1'b1) begin
         nack++;
         if (q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_ack: ack_vld=1 at cycle %0d, required 0",
                     cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, "_rdata"}, 128'(rd_data), 128'(e.rd));
            chk({e.nm, "_ack_cycle"}, 128'(cyc), 128'(e.cyc));
         end
      end else begin
         chk("idle_rdata", 128'(rd_data), 128'd0);
      end
   end

   // ext_mem_1 model: ack after ext_dly cycles, read data taken at ack time
   initial begin
      logic [0:0] a;
      x_ack   = 1'b0;
      x_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (x_req === 1'b1) begin
            a = x_addr;
            if (x_wr) begin
               ext_wr_cnt++;
               mem[a]     = x_wdata;
               last_wdata = x_wdata;
               last_waddr = a;
            end
            if (x_rd) ext_rd_cnt++;
            repeat (ext_dly) @(posedge clk);
            #1;
            x_ack   = 1'b1;
            x_rdata = mem[a];
            @(posedge clk);
            #1;
            x_ack   = 1'b0;
            x_rdata = '0;
         end
      end
   end

   task automatic issue(input bit w, input bit r, input logic [63:0] a,
                        input logic [31:0] d, input bit push,
                        input logic [31:0] erd, input int lat,
                        input string nm);
      @(posedge clk);
      #1;
      req_vld = 1'b1;
      wr_en   = w;
      rd_en   = r;
      addr    = a;
      wr_data = d;
      if (push) begin
         exp_t e;
         e.rd  = erd;
         e.cyc = cyc + lat;
         e.nm  = nm;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_vld = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      addr    = '0;
      wr_data = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (q.size() != 0) begin
         nvec++;
         nfail++;
         $display("FAIL ack_timeout: %0d acks outstanding, required 0",
                  q.size());
         q.delete();
      end
   endtask

   task automatic req(input bit w, input bit r, input logic [63:0] a,
                      input logic [31:0] d, input logic [31:0] erd,
                      input int lat, input string nm);
      issue(w, r, a, d, 1'b1, erd, lat, nm);
      drain();
   endtask

   task automatic hw(input logic [63:0] v);
      @(posedge clk);
      #1;
      hw_nv    = v;
      hw_pulse = 1'b1;
      @(posedge clk);
      #1;
      hw_pulse = 1'b0;
   endtask

   initial begin
      int w0;
      int r0;
      int a0;
      fsm_rst  = 1'b1;
      req_vld  = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      addr     = '0;
      wr_data  = '0;
      hw_nv    = '0;
      hw_pulse = 1'b0;
      gsr_in   = 1'b0;
      mem[0]   = '0;
      mem[1]   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 128'(ack_vld), 128'd0);
      chk("rst_curr", 128'(curr), 128'd0);
      chk("rst_ext_req", 128'(x_req), 128'd0);
      chk("rst_gsr_out", 128'(gsr_out), 128'd0);
      fsm_rst = 1'b0;

      req(1, 0, 64'h04, 32'h11111111, 32'h0, 1, "wr_04");
      chk("curr_after_wr04", 128'(curr), 128'd0);
      hw(64'hAAAAAAAA_AAAAAAAA);
      chk("curr_hw", 128'(curr), 128'hAAAAAAAA_AAAAAAAA);
      req(1, 0, 64'h00, 32'h22222222, 32'h0, 1, "wr_00");
      chk("curr_commit", 128'(curr), 128'h11111111_22222222);

      req(0, 1, 64'h00, 32'h0, 32'h22222222, 1, "rd_00");
      hw(64'hAAAAAAAA_AAAAAAAA);
      chk("curr_hw2", 128'(curr), 128'hAAAAAAAA_AAAAAAAA);
      req(0, 1, 64'h04, 32'h0, 32'h11111111, 1, "rd_04_snap");

      req(1, 1, 64'h04, 32'h33333333, 32'h0, 1, "wrrd_04");
      hw_nv    = 64'h55555555_55555555;
      hw_pulse = 1'b1;
      issue(1, 0, 64'h00, 32'h44444444, 1'b1, 32'h0, 1, "wr_00_race");
      hw_pulse = 1'b0;
      drain();
      chk("commit_wins", 128'(curr), 128'h33333333_44444444);

      w0 = ext_wr_cnt;
      req(1, 0, 64'h2C, 32'hFFFFFFFF, 32'h0, 1, "wr_2c");
      req(1, 0, 64'h28, 32'hFFFFFFFF, 32'h0, 1, "wr_28");
      mem[0] = ALL_A;
      req(1, 0, 64'h24, 32'hFFFFFFFF, 32'h0, 1, "wr_24");
      chk("ent0_untouched", mem[0], ALL_A);
      chk("no_ext_wr_yet", 128'(ext_wr_cnt), 128'(w0));
      req(1, 0, 64'h20, 32'hFFFFFFFF, 32'h0, 4, "wr_20");
      chk("one_ext_wr", 128'(ext_wr_cnt), 128'(w0 + 1));
      chk("ext_wdata", last_wdata, ALL_F);
      chk("ext_waddr", 128'(last_waddr), 128'd0);

      r0 = ext_rd_cnt;
      req(0, 1, 64'h20, 32'h0, 32'hFFFFFFFF, 4, "rd_20");
      mem[0] = ALL_A;
      req(0, 1, 64'h24, 32'h0, 32'hFFFFFFFF, 1, "rd_24");
      req(0, 1, 64'h28, 32'h0, 32'hFFFFFFFF, 1, "rd_28");
      req(0, 1, 64'h2C, 32'h0, 32'hFFFFFFFF, 1, "rd_2c");
      chk("one_ext_rd", 128'(ext_rd_cnt), 128'(r0 + 1));
      chk("no_extra_ext_wr", 128'(ext_wr_cnt), 128'(w0 + 1));

      req(1, 0, 64'h3C, 32'h12345678, 32'h0, 1, "wr_3c");
      req(1, 0, 64'h30, 32'h9ABCDEF0, 32'h0, 4, "wr_30");
      chk("ent1_data", mem[1],
          {32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9ABCDEF0});
      chk("ent1_waddr", 128'(last_waddr), 128'd1);

      ext_dly = 5;
      issue(0, 1, 64'h30, 32'h0, 1'b1, 32'h9ABCDEF0, 7, "rd_30_slow");
      repeat (2) @(posedge clk);
      issue(1, 0, 64'h00, 32'hDEADBEEF, 1'b0, 32'h0, 0, "dropped");
      drain();
      chk("drop_curr", 128'(curr), 128'h33333333_44444444);
      ext_dly = 2;

      @(posedge clk);
      #1;
      gsr_in = 1'b1;
      @(posedge clk);
      #1;
      gsr_in = 1'b0;
      chk("soft_rst_curr", 128'(curr), 128'd0);
      chk("gsr_out_hi", 128'(gsr_out), 128'd1);
      @(posedge clk);
      #1;
      chk("gsr_out_lo", 128'(gsr_out), 128'd0);
      req(0, 1, 64'h100, 32'h0, 32'h0, 1, "rd_unmapped");
      req(0, 1, 64'h04, 32'h0, 32'h0, 1, "rd_04_cleared");
      req(0, 1, 64'h24, 32'h0, 32'h0, 1, "rd_24_cleared");

      ext_dly = 5;
      a0 = nack;
      issue(0, 1, 64'h20, 32'h0, 1'b0, 32'h0, 0, "aborted");
      @(posedge clk);
      #1;
      fsm_rst = 1'b1;
      gsr_in  = 1'b1;
      @(posedge clk);
      #1;
      chk("gsr_out_in_rst", 128'(gsr_out), 128'd0);
      fsm_rst = 1'b0;
      gsr_in  = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("abort_no_ack", 128'(nack), 128'(a0));
      ext_dly = 2;

      req(1, 0, 64'h00, 32'hCAFEF00D, 32'h0, 1, "wr_00_post");
      chk("curr_post", 128'(curr), 128'h00000000_CAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regslv_reg_block_1.md
REGSLV_REG_BLOCK_1 -- requirements
Module: regslv_reg_block_1

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 64, upstream address width; DATA_WIDTH, default 32, upstream data width; EXT_ADDR_WIDTH, default 1, ext_mem_1 address width; EXT_DATA_WIDTH, default 128, ext_mem_1 data width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- fsm_clk, in, 1, the single clock for the whole block.
- fsm_rst, in, 1, reset; synchronous, active-high.
- req_vld, in, 1, upstream request pulse.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- addr, in, ADDR_WIDTH, byte address.
- wr_data, in, DATA_WIDTH, write data.
- ack_vld, out, 1, one-cycle completion pulse.
- rd_data, out, DATA_WIDTH, read data, valid with ack_vld.
- ext_mem_1_req_vld, out, 1, ext request pulse.
- ext_mem_1_wr_en, out, 1, ext write.
- ext_mem_1_rd_en, out, 1, ext read.
- ext_mem_1_addr, out, EXT_ADDR_WIDTH, ext entry index.
- ext_mem_1_wr_data, out, EXT_DATA_WIDTH, ext write data.
- ext_mem_1_ack_vld, in, 1, ext completion pulse.
- ext_mem_1_rd_data, in, EXT_DATA_WIDTH, ext read data.
- REG1__FIELD_0__next_value, in, 64, hardware write value.
- REG1__FIELD_0__pulse, in, 1, hardware write strobe.
- REG1__FIELD_0__curr_value, out, 64, current REG1 value.
- global_sync_reset_in, in, 1, soft reset from upstream.
- global_sync_reset_out, out, 1, soft reset to downstream.

Function
REQ-003 The address map SHALL be: REG1 word w (w = 0..1) at byte address 0x00 + 4w; ext_mem_1 entry e (0..1), word w (0..3) at byte address 0x20 + 16e + 4w. Bus word w SHALL map to bits [32w+31:32w]. Any other address is unmapped.
REQ-004 Each target SHALL have one snapshot buffer sized to its full width: 64 bits for REG1, 128 bits for ext_mem_1. Reads and writes to the same target share that buffer.
REQ-005 A write to word w != 0 SHALL only update that word of the target's snapshot buffer. The target itself is unchanged.
REQ-006 A write to word 0 SHALL commit {buffer upper words, wr_data} atomically to the target.
REQ-007 A read of word 0 SHALL capture the full target value into the snapshot buffer and return bits [31:0].
REQ-008 A read of word w != 0 SHALL return snapshot word w. It SHALL NOT access the target.
REQ-009 The FSM SHALL have the states IDLE, INT, EXT_REQ, EXT_WAIT and ACK.
- IDLE leaves on req_vld with wr_en or rd_en set.
- Requests arriving while not in IDLE are ignored.
REQ-010 REG1 accesses and all snapshot-only accesses (including unmapped addresses) SHALL raise ack_vld exactly 1 cycle after req_vld.
REQ-011 An ext_mem_1 word-0 access SHALL pulse ext_mem_1_req_vld for one cycle, 1 cycle after req_vld, with wr_en/rd_en/addr/wr_data driven.
- The block then waits in EXT_WAIT with no timeout.
- It asserts ack_vld 1 cycle after ext_mem_1_ack_vld.
- On a read, the snapshot and rd_data are taken from ext_mem_1_rd_data.
REQ-012 ext_mem_1 write data on commit SHALL be {snapshot[127:32], wr_data}.
REQ-013 ack_vld SHALL be a single-cycle pulse. rd_data SHALL be 0 on writes, on unmapped reads, and while ack_vld is low.
REQ-014 REG1 SHALL load REG1__FIELD_0__next_value on any cycle where REG1__FIELD_0__pulse=1, except that a software commit in the same cycle wins.
REQ-015 REG1__FIELD_0__curr_value SHALL equal the REG1 register with zero latency.
REQ-016 A request with both wr_en and rd_en set SHALL be treated as a write.

Reset
REQ-017 While fsm_rst=1 or global_sync_reset_in=1, on the next clock:
- REG1 = 0 and both snapshot buffers = 0.
- FSM = IDLE.
- ack_vld, rd_data and all ext_mem_1 outputs = 0.
REQ-018 global_sync_reset_out SHALL be global_sync_reset_in registered by one cycle, and SHALL be 0 during fsm_rst.
REQ-019 A reset in mid-operation SHALL abort the transaction with no ack_vld, and any late ext_mem_1_ack_vld SHALL be ignored.

Verification
REQ-020 Write 0x04=0x11111111 -> curr_value stays 0. Then pulse hw 0xAAAAAAAA_AAAAAAAA, then write 0x00=0x22222222 -> curr_value = 0x11111111_22222222.
REQ-021 Read 0x00 -> 0x22222222. Then pulse hw 0xAAAAAAAA_AAAAAAAA, then read 0x04 -> 0x11111111 (snapshot value), with ack 1 cycle after each req.
REQ-022 Write 0xFFFFFFFF to 0x2C, 0x28, 0x24, forcing ext_mem_1 entry 0 to all-0xA after the second write -> entry 0 unchanged until the 0x20 write, then exactly one ext write, data 0xFF..FF (128 bits).
REQ-023 Read 0x20 (one ext read), force entry 0 to all-0xA, then read 0x24, 0x28, 0x2C -> all four reads return 0xFFFFFFFF and there are no further ext requests.
REQ-024 Ext ack delayed 5 cycles -> upstream ack_vld occurs exactly 1 cycle after ext_mem_1_ack_vld. A request issued while busy is dropped.
REQ-025 Pulse global_sync_reset_in with REG1 nonzero -> REG1 = 0 next cycle, and global_sync_reset_out pulses one cycle later. Read of unmapped 0x100 -> ack_vld after 1 cycle with rd_data 0.
